// File: rtl/crc_frame_pkg.sv
// rtl/crc_frame_pkg.sv - shared state type, default widths and counter sizing for the CRC frame driver
package crc_frame_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, COLLECT} state_t;

    localparam int DATA_W = 8;
    localparam int CRC_W  = 8;

    // One counter width covers the bit counter, the CRC bit index and the timeout counter
    function automatic int cnt_width(input int data_width, input int crc_width, input int timeout);
        int m;
        m = data_width;
        if (crc_width > m) m = crc_width;
        if (timeout > m) m = timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/crc_frame_driver_if.sv
// rtl/crc_frame_driver_if.sv - byte handshake and CRC engine signals of the CRC frame driver
interface crc_frame_driver_if
    import crc_frame_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int CRC_WIDTH  = CRC_W
);
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  IN_VALID;
    logic                  IN_READY;
    logic                  ACTIVE;
    logic                  SER_DATA;
    logic                  CRC_BIT;
    logic                  CRC_VALID;
    logic [CRC_WIDTH-1:0]  CRC_OUT;
    logic                  OUT_VALID;
    logic                  ERR;

    modport slave (
        input  DATA_IN, IN_VALID, CRC_BIT, CRC_VALID,
        output IN_READY, ACTIVE, SER_DATA, CRC_OUT, OUT_VALID, ERR
    );

    modport master (
        output DATA_IN, IN_VALID, CRC_BIT, CRC_VALID,
        input  IN_READY, ACTIVE, SER_DATA, CRC_OUT, OUT_VALID, ERR
    );
endinterface

// File: rtl/crc_bit_collector.sv
// rtl/crc_bit_collector.sv - serial-to-parallel capture of CRC bits, first received bit lands in the LSB
module crc_bit_collector
    import crc_frame_pkg::*;
#(
    parameter int CRC_WIDTH = CRC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] data,
    output logic                 done
);
    localparam int KW = $clog2(CRC_WIDTH + 1);
    localparam logic [KW-1:0] LAST_K = KW'(CRC_WIDTH - 1);

    logic [KW-1:0] k;

    // Shifting in from the top leaves the first bit at data[0] once all bits arrived
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            k    <= '0;
            done <= 1'b0;
            data <= '0;
        end else if (en && !done) begin
            data <= {bit_in, data[CRC_WIDTH-1:1]};
            k    <= k + 1'b1;
            if (k == LAST_K) done <= 1'b1;
        end
    end

endmodule

// File: rtl/crc_frame_driver.sv
// rtl/crc_frame_driver.sv - serializes a byte into CRC_REG and collects its serial CRC as one parallel byte
module crc_frame_driver
    import crc_frame_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int CRC_WIDTH  = CRC_W,
    parameter int TIMEOUT    = 16
) (
    input logic              CLK,
    input logic              RST,
    crc_frame_driver_if.slave bus
);
    localparam int CW = cnt_width(DATA_WIDTH, CRC_WIDTH, TIMEOUT);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT - 1);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]         bit_cnt, bit_cnt_n;
    logic [CW-1:0]         tcnt, tcnt_n;
    logic                  in_ready, in_ready_n;
    logic                  active, active_n;
    logic                  out_valid, out_valid_n;
    logic                  err, err_n;
    logic [CRC_WIDTH-1:0]  crc_out, crc_out_n;

    logic [CRC_WIDTH-1:0]  capture;
    logic                  cap_done;
    logic                  cap_en;
    logic                  cap_clear;

    assign cap_en    = (state == COLLECT) && bus.CRC_VALID;
    assign cap_clear = (state != COLLECT);

    crc_bit_collector #(.CRC_WIDTH(CRC_WIDTH)) u_collector (
        .clk    (CLK),
        .rst    (RST),
        .clear  (cap_clear),
        .en     (cap_en),
        .bit_in (bus.CRC_BIT),
        .data   (capture),
        .done   (cap_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            tcnt      <= '0;
            in_ready  <= 1'b0;
            active    <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            crc_out   <= '0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            tcnt      <= tcnt_n;
            in_ready  <= in_ready_n;
            active    <= active_n;
            out_valid <= out_valid_n;
            err       <= err_n;
            crc_out   <= crc_out_n;
        end
    end

    // The shift register empties to zero after the last bit, so SER_DATA is low whenever ACTIVE is
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        tcnt_n      = tcnt;
        active_n    = active;
        crc_out_n   = crc_out;
        out_valid_n = 1'b0;
        err_n       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.IN_VALID && in_ready) begin
                    shreg_n   = bus.DATA_IN;
                    bit_cnt_n = '0;
                    active_n  = 1'b1;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_n   = shreg >> 1;
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    active_n = 1'b0;
                    tcnt_n   = '0;
                    state_n  = COLLECT;
                end
            end
            COLLECT: begin
                if (cap_done) begin
                    crc_out_n   = capture;
                    out_valid_n = 1'b1;
                    state_n     = IDLE;
                end else if (bus.CRC_VALID) begin
                    tcnt_n = '0;
                end else if (tcnt == LAST_IDLE) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        in_ready_n = (state_n == IDLE);
    end

    assign bus.IN_READY  = in_ready;
    assign bus.ACTIVE    = active;
    assign bus.SER_DATA  = shreg[0];
    assign bus.OUT_VALID = out_valid;
    assign bus.ERR       = err;
    assign bus.CRC_OUT   = crc_out;

endmodule

// File: tb/tb_crc_frame_driver.sv
// tb/tb_crc_frame_driver.sv - directed and randomized frames against a behavioural CRC_REG stand-in
module tb_crc_frame_driver;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int TO = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_a, acc_b;
    logic [CW-1:0] exp_crc = '0;

    crc_frame_driver_if #(.DATA_WIDTH(DW), .CRC_WIDTH(CW)) bus ();

    crc_frame_driver #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: byte d in, stub returns pat with gap_len idle cycles before CRC bit gap_at.
    // Cycle c counts from the accept edge; the expected timeline follows from the frame rules.
    task automatic run_frame(input logic [DW-1:0] d, input logic [CW-1:0] pat,
                             input int gap_at, input int gap_len,
                             input bit no_valid, input bit hold, output int acc_cyc);
        int n;
        int k;
        int e;
        bus.DATA_IN  = d;
        bus.IN_VALID = 1'b1;
        n = 0;
        while (bus.IN_READY !== 1'b1 && n < 50) begin
            bus.CRC_VALID = 1'($urandom);
            bus.CRC_BIT   = 1'($urandom);
            @(negedge CLK);
            n++;
        end
        check("ready_wait", 32'(n < 50), 32'd1);
        @(negedge CLK);
        acc_cyc = cyc;
        e = no_valid ? DW + TO : DW + CW + 1 + gap_len;
        k = 0;
        for (int c = 0; c <= e; c++) begin
            check("active", 32'(bus.ACTIVE), 32'(c < DW));
            check("ser_data", 32'(bus.SER_DATA), 32'((c < DW) ? d[c] : 1'b0));
            check("in_ready", 32'(bus.IN_READY), 32'(c >= e));
            check("out_valid", 32'(bus.OUT_VALID), 32'(!no_valid && c == e));
            check("err", 32'(bus.ERR), 32'(no_valid && c == e));
            if (c == e && !no_valid) exp_crc = pat;
            check("crc_out", 32'(bus.CRC_OUT), 32'(exp_crc));
            if (!hold) bus.IN_VALID = 1'b0;
            if (c < DW) begin
                bus.CRC_VALID = 1'($urandom);
                bus.CRC_BIT   = 1'($urandom);
            end else if (!no_valid && k < CW && c == DW + k + ((k >= gap_at) ? gap_len : 0)) begin
                bus.CRC_VALID = 1'b1;
                bus.CRC_BIT   = pat[k];
                k++;
            end else begin
                bus.CRC_VALID = 1'b0;
                bus.CRC_BIT   = 1'($urandom);
            end
            if (c < e) @(negedge CLK);
        end
    endtask

    initial begin
        bus.DATA_IN   = '0;
        bus.IN_VALID  = 1'b0;
        bus.CRC_BIT   = 1'b0;
        bus.CRC_VALID = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_in_ready", 32'(bus.IN_READY), 32'd0);
        check("rst_active", 32'(bus.ACTIVE), 32'd0);
        check("rst_ser_data", 32'(bus.SER_DATA), 32'd0);
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_err", 32'(bus.ERR), 32'd0);
        check("rst_crc_out", 32'(bus.CRC_OUT), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_in_ready", 32'(bus.IN_READY), 32'd1);

        run_frame(8'hA5, 8'h3C, 8, 0, 1'b0, 1'b0, acc_a);

        run_frame(8'h00, 8'($urandom), 8, 0, 1'b0, 1'b1, acc_a);
        run_frame(8'hFF, 8'($urandom), 8, 0, 1'b0, 1'b0, acc_b);
        check("frame_period", 32'(acc_b - acc_a), 32'(DW + CW + 2));

        run_frame(8'($urandom), 8'h81, 4, 3, 1'b0, 1'b0, acc_a);
        run_frame(8'($urandom), 8'($urandom), 0, 0, 1'b1, 1'b0, acc_a);
        check("crc_kept_after_err", 32'(bus.CRC_OUT), 32'h81);

        // Reset during the fourth SHIFT cycle
        bus.DATA_IN  = 8'hC3;
        bus.IN_VALID = 1'b1;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("mid_active", 32'(bus.ACTIVE), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_active", 32'(bus.ACTIVE), 32'd0);
        check("mid_rst_ser_data", 32'(bus.SER_DATA), 32'd0);
        check("mid_rst_in_ready", 32'(bus.IN_READY), 32'd0);
        check("mid_rst_crc_out", 32'(bus.CRC_OUT), 32'd0);
        exp_crc = '0;
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.CRC_VALID = 1'b1;
            bus.CRC_BIT   = 1'($urandom);
            @(negedge CLK);
            check("mid_no_out_valid", 32'(bus.OUT_VALID), 32'd0);
            check("mid_no_err", 32'(bus.ERR), 32'd0);
            check("mid_idle_ready", 32'(bus.IN_READY), 32'd1);
        end
        bus.CRC_VALID = 1'b0;
        run_frame(8'h5A, 8'($urandom), 8, 0, 1'b0, 1'b0, acc_a);

        for (int f = 0; f < 6; f++) begin
            run_frame(8'($urandom), 8'($urandom), int'($urandom_range(0, CW - 1)),
                      int'($urandom_range(0, TO - 1)), 1'b0, 1'($urandom), acc_a);
        end

        bus.IN_VALID  = 1'b0;
        bus.CRC_VALID = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            check("tail_out_valid", 32'(bus.OUT_VALID), 32'd0);
            check("tail_crc_out", 32'(bus.CRC_OUT), 32'(exp_crc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
